// File: rtl/axi_pkg.sv
// Shared AXI constants and the instruction-side read FSM states.
// Imported by the L1 I-cache refill master and its interface.
package axi_pkg;

    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        IRD_IDLE,
        IRD_ADDR,
        IRD_DATA,
        IRD_HOLD
    } ird_state_e;

endpackage

// File: rtl/l1ci_axi_read_master_if.sv
// AXI4 read-address and read-data channels of the I-side master port.
// The master drives AR and RREADY; the slave drives ARREADY and R.
interface l1ci_axi_read_master_if #(
    parameter int ID_W = 4
);

    logic [ID_W-1:0] ARID;
    logic [31:0]     ARADDR;
    logic [3:0]      ARLEN;
    logic [2:0]      ARSIZE;
    logic [1:0]      ARBURST;
    logic            ARVALID;
    logic            ARREADY;

    logic [ID_W-1:0] RID;
    logic [31:0]     RDATA;
    logic [1:0]      RRESP;
    logic            RLAST;
    logic            RVALID;
    logic            RREADY;

    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY
    );

    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY
    );

endinterface

// File: rtl/l1ci_axi_read_master.sv
// I-cache refill master: one line-aligned INCR burst per miss,
// beats streamed straight to the cache, sticky error flags.
module l1ci_axi_read_master
    import axi_pkg::*;
#(
    parameter int              ID_W        = 4,
    parameter logic [ID_W-1:0] AR_ID       = '0,
    parameter int              BURST_BEATS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        I_req,
    input  logic [31:0] I_addr,
    output logic [31:0] I_out,
    output logic        RVALID_c,
    output logic        RLAST_c,
    output logic        busy,
    output logic        err,
    output logic        proto_err,
    l1ci_axi_read_master_if.master axi
);

    localparam int CNT_W = $clog2(BURST_BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_BEATS - 1);

    ird_state_e       state_q;
    ird_state_e       state_d;
    logic [31:0]      addr_q;
    logic [CNT_W-1:0] beat_cnt;
    logic             err_q;
    logic             proto_q;
    logic             beat_ok;
    logic             final_beat;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IRD_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        axi.ARVALID = 1'b0;
        axi.RREADY  = 1'b0;
        beat_ok     = 1'b0;
        final_beat  = 1'b0;
        unique case (state_q)
            IRD_IDLE: begin
                if (I_req) state_d = IRD_ADDR;
            end
            IRD_ADDR: begin
                axi.ARVALID = 1'b1;
                if (axi.ARREADY) state_d = IRD_DATA;
            end
            IRD_DATA: begin
                // Foreign-ID beats are drained but never reach the cache
                axi.RREADY = 1'b1;
                beat_ok    = axi.RVALID && (axi.RID == AR_ID);
                final_beat = beat_ok && (beat_cnt == LAST_BEAT);
                if (final_beat) state_d = IRD_HOLD;
            end
            IRD_HOLD: begin
                if (!I_req) state_d = IRD_IDLE;
            end
            default: state_d = IRD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            beat_cnt <= '0;
            err_q    <= 1'b0;
            proto_q  <= 1'b0;
        end else begin
            if (state_q == IRD_IDLE && I_req) begin
                addr_q   <= {I_addr[31:4], 4'b0000};
                beat_cnt <= '0;
            end
            if (beat_ok) begin
                if (beat_cnt != LAST_BEAT) beat_cnt <= beat_cnt + 1'b1;
                if (axi.RRESP != AXI_RESP_OKAY) err_q <= 1'b1;
                // RLAST must coincide exactly with our own final beat
                if (axi.RLAST != final_beat) proto_q <= 1'b1;
            end
        end
    end

    assign axi.ARID    = AR_ID;
    assign axi.ARADDR  = addr_q;
    assign axi.ARLEN   = 4'(BURST_BEATS - 1);
    assign axi.ARSIZE  = AXI_SIZE_4B;
    assign axi.ARBURST = AXI_BURST_INCR;

    assign I_out     = beat_ok ? axi.RDATA : 32'h0;
    assign RVALID_c  = beat_ok;
    assign RLAST_c   = final_beat;
    assign busy      = (state_q != IRD_IDLE);
    assign err       = err_q;
    assign proto_err = proto_q;

endmodule

// File: tb/tb_l1ci_axi_read_master.sv
// Directed and randomized refill bursts against a beat-level model
// of the I-side AXI read master.
module tb_l1ci_axi_read_master;
    import axi_pkg::*;

    localparam int BEATS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        I_req;
    logic [31:0] I_addr;
    logic [31:0] I_out;
    logic        RVALID_c;
    logic        RLAST_c;
    logic        busy;
    logic        err;
    logic        proto_err;

    int checks   = 0;
    int failures = 0;
    bit m_err    = 1'b0;
    bit m_proto  = 1'b0;

    l1ci_axi_read_master_if #(.ID_W(4)) bus ();

    l1ci_axi_read_master #(
        .ID_W(4),
        .AR_ID(4'd0),
        .BURST_BEATS(BEATS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .I_req(I_req),
        .I_addr(I_addr),
        .I_out(I_out),
        .RVALID_c(RVALID_c),
        .RLAST_c(RLAST_c),
        .busy(busy),
        .err(err),
        .proto_err(proto_err),
        .axi(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.ARREADY = 1'b0;
        bus.RVALID  = 1'b0;
        bus.RID     = 4'd0;
        bus.RDATA   = 32'h0;
        bus.RRESP   = AXI_RESP_OKAY;
        bus.RLAST   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        I_req = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        #1;
        m_err   = 1'b0;
        m_proto = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_arvalid", bus.ARVALID, 0);
        chk("rst_rready", bus.RREADY, 0);
        chk("rst_rvalid_c", RVALID_c, 0);
        chk("rst_rlast_c", RLAST_c, 0);
        chk("rst_i_out", I_out, 0);
        chk("rst_err", err, 0);
        chk("rst_proto", proto_err, 0);
        chk("rst_araddr", bus.ARADDR, 0);
        chk("rst_arid", bus.ARID, 0);
        chk("rst_arlen", bus.ARLEN, BEATS - 1);
        rst = 1'b0;
    endtask

    // mode: 0 back-to-back, 1 valid pattern vpat, 2 random gaps + foreign IDs
    task automatic run_burst(input logic [31:0] addr, input int ar_wait,
                             input int mode, input logic [15:0] vpat,
                             input logic [3:0] bad, input logic [3:0] rl,
                             input int hold_n, input bit ar_with_r);
        int          beat;
        int          cyc;
        bit          v;
        bit          foreign;
        logic [31:0] d;
        @(negedge clk);
        idle_inputs();
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_arvalid", bus.ARVALID, 0);
        I_req  = 1'b1;
        I_addr = addr;
        for (int w = 0; w <= ar_wait; w++) begin
            @(negedge clk);
            idle_inputs();
            bus.ARREADY = (w == ar_wait);
            if (w == ar_wait && ar_with_r) begin
                bus.RVALID = 1'b1;
                bus.RDATA  = 32'hDEAD_BEEF;
                bus.RLAST  = 1'b0;
            end
            #1;
            chk("ar_valid", bus.ARVALID, 1);
            chk("ar_addr", bus.ARADDR, {addr[31:4], 4'h0});
            chk("ar_len", bus.ARLEN, BEATS - 1);
            chk("ar_size", bus.ARSIZE, 3'b010);
            chk("ar_burst", bus.ARBURST, 2'b01);
            chk("addr_rready", bus.RREADY, 0);
            chk("addr_rvalid_c", RVALID_c, 0);
        end
        beat = 0;
        cyc  = 0;
        while (beat < BEATS && cyc < 64) begin
            @(negedge clk);
            idle_inputs();
            cyc++;
            foreign = 1'b0;
            case (mode)
                0: v = 1'b1;
                1: v = vpat[(cyc - 1) % 16];
                default: begin
                    v       = ($urandom_range(0, 2) != 0);
                    foreign = ($urandom_range(0, 4) == 0);
                end
            endcase
            d = $urandom;
            if (v && foreign) begin
                bus.RVALID = 1'b1;
                bus.RID    = 4'd5;
                bus.RDATA  = d;
                bus.RLAST  = 1'($urandom_range(0, 1));
                #1;
                chk("foreign_rvalid_c", RVALID_c, 0);
                chk("foreign_rready", bus.RREADY, 1);
            end else if (v) begin
                bus.RVALID = 1'b1;
                bus.RDATA  = d;
                bus.RRESP  = bad[beat] ? 2'b10 : AXI_RESP_OKAY;
                bus.RLAST  = rl[beat];
                #1;
                chk("beat_rvalid_c", RVALID_c, 1);
                chk("beat_data", I_out, d);
                chk("beat_rlast_c", RLAST_c, beat == BEATS - 1);
                chk("beat_err", err, m_err);
                chk("beat_proto", proto_err, m_proto);
                m_err   = m_err | bad[beat];
                m_proto = m_proto | (rl[beat] != (beat == BEATS - 1));
                beat++;
            end else begin
                #1;
                chk("gap_rvalid_c", RVALID_c, 0);
                chk("gap_i_out", I_out, 0);
                chk("gap_rready", bus.RREADY, 1);
            end
        end
        if (beat < BEATS) begin
            checks++;
            failures++;
            $error("FAIL beat_timeout observed=%0d expected=%0d", beat, BEATS);
        end
        for (int h = 0; h < hold_n; h++) begin
            @(negedge clk);
            idle_inputs();
            #1;
            chk("hold_arvalid", bus.ARVALID, 0);
            chk("hold_rready", bus.RREADY, 0);
            chk("hold_busy", busy, 1);
        end
        @(negedge clk);
        idle_inputs();
        I_req = 1'b0;
        #1;
        chk("drop_busy", busy, 1);
        chk("drop_arvalid", bus.ARVALID, 0);
        chk("end_err", err, m_err);
        chk("end_proto", proto_err, m_proto);
    endtask

    initial begin
        rst    = 1'b1;
        I_req  = 1'b0;
        I_addr = 32'h0;
        idle_inputs();
        do_reset();

        run_burst(32'h0000_1234, 2, 0, 16'h0, 4'b0000, 4'b1000, 0, 1'b0);
        run_burst($urandom, 1, 1, 16'h0059, 4'b0000, 4'b1000, 1, 1'b0);
        run_burst($urandom, 0, 0, 16'h0, 4'b0010, 4'b1000, 0, 1'b0);
        run_burst($urandom, 1, 2, 16'h0, 4'b0000, 4'b1000, 1, 1'b0);

        run_burst($urandom, 0, 0, 16'h0, 4'b0000, 4'b1010, 0, 1'b0);
        do_reset();
        run_burst($urandom, 0, 0, 16'h0, 4'b0000, 4'b0000, 0, 1'b0);
        do_reset();

        run_burst($urandom, 1, 0, 16'h0, 4'b0000, 4'b1000, 3, 1'b0);
        run_burst($urandom, 0, 0, 16'h0, 4'b0000, 4'b1000, 0, 1'b1);

        for (int n = 0; n < 6; n++) begin
            run_burst($urandom, $urandom_range(0, 3), 2, 16'h0,
                      4'($urandom_range(0, 15) == 0 ? 4'b0100 : 4'b0000),
                      4'b1000, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        // abort after two beats, one of them an error response
        @(negedge clk);
        idle_inputs();
        I_req  = 1'b1;
        I_addr = 32'hABCD_0008;
        @(negedge clk);
        idle_inputs();
        bus.ARREADY = 1'b1;
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            idle_inputs();
            bus.RVALID = 1'b1;
            bus.RDATA  = 32'h1000 + b;
            bus.RRESP  = (b == 0) ? 2'b10 : AXI_RESP_OKAY;
            #1;
            chk("abort_beat", I_out, 32'h1000 + b);
        end
        @(negedge clk);
        idle_inputs();
        I_req = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        m_err   = 1'b0;
        m_proto = 1'b0;
        chk("abort_arvalid", bus.ARVALID, 0);
        chk("abort_rready", bus.RREADY, 0);
        chk("abort_busy", busy, 0);
        chk("abort_err", err, 0);
        run_burst($urandom, 0, 0, 16'h0, 4'b0000, 4'b1000, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/l1ci_axi_read_master.md
# l1ci_axi_read_master

Instruction-side AXI4 read master between the L1 instruction cache miss interface and the CPU wrapper's AXI master port 0. It turns a line-aligned cache refill request into one 4-beat INCR burst and streams each beat back to the cache. It also reports bus errors and protocol mismatches through sticky status bits.

## Interface
Parameters:
- `ID_W`, default 4: AXI ID width.
- `AR_ID`, default 4'd0: ID driven on ARID; R beats with any other RID are ignored.
- `BURST_BEATS`, default 4: beats per refill. ARLEN = BURST_BEATS-1. Must be a power of two, 2 to 16.

Ports:
- `clk` in 1: clock. Everything is synchronous to its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `I_req` in 1: refill request from the cache. Held high until the cache has seen the last beat.
- `I_addr` in 32: refill address. Bits [3:0] are ignored and forced to 0.
- `I_out` out 32: beat data returned to the cache.
- `RVALID_c` out 1: `I_out` carries a valid accepted beat this cycle.
- `RLAST_c` out 1: this beat is the final beat.
- `busy` out 1: a transaction is in flight.
- `err` out 1: sticky bus error (RRESP != OKAY). Cleared only by `rst`.
- `proto_err` out 1: sticky protocol error (RLAST on the wrong beat). Cleared only by `rst`.
- AR channel:
  - `ARID` out ID_W
  - `ARADDR` out 32
  - `ARLEN` out 4
  - `ARSIZE` out 3, fixed 3'b010
  - `ARBURST` out 2, fixed INCR 2'b01
  - `ARVALID` out 1
  - `ARREADY` in 1
- R channel:
  - `RID` in ID_W
  - `RDATA` in 32
  - `RRESP` in 2
  - `RLAST` in 1
  - `RVALID` in 1
  - `RREADY` out 1

## Operation
States: IDLE, ADDR, DATA, HOLD.
- IDLE:
  - If `I_req` is high: latch {I_addr[31:4],4'b0} into `addr_q`, clear `beat_cnt`, go to ADDR.
  - Otherwise stay in IDLE.
- ADDR:
  - ARVALID=1. ARADDR=`addr_q`, ARLEN=BURST_BEATS-1, ARID=AR_ID.
  - On ARREADY, go to DATA. All AR fields stay stable while ARVALID=1.
- DATA:
  - RREADY=1.
  - A beat is accepted when RVALID && RREADY && RID==AR_ID.
  - On each accepted beat:
    - `I_out` = RDATA and `RVALID_c` = 1, both combinational.
    - `beat_cnt` increments.
    - If RRESP != 2'b00, set `err`.
  - Final beat is when `beat_cnt` == BURST_BEATS-1:
    - `RLAST_c` = 1, go to HOLD.
    - If RLAST=0 on this beat, set `proto_err`.
  - Early RLAST (RLAST=1 before the final beat) sets `proto_err`. The FSM still waits for the full beat count.
  - Beats with RID != AR_ID: RREADY stays 1, the beat is dropped, `RVALID_c`=0.
- HOLD:
  - Wait for `I_req`=0, then go to IDLE.
  - This prevents a second burst while the cache is still holding `I_req` through its end-of-refill cycle.
- `busy` = (state != IDLE).
- Outside DATA: `I_out`=0, `RVALID_c`=0, `RLAST_c`=0, RREADY=0.
- `beat_cnt` width is log2(BURST_BEATS). It saturates at BURST_BEATS-1 and never wraps.

## Timing
- Reset values (the cycle after `rst` is sampled high):
  - state=IDLE, `addr_q`=0, `beat_cnt`=0.
  - ARVALID=0, RREADY=0, `RVALID_c`=0, `RLAST_c`=0, `I_out`=0.
  - `err`=0, `proto_err`=0, `busy`=0.
  - ARADDR=0, ARID=AR_ID, ARLEN=BURST_BEATS-1.
- Reset during ADDR or DATA aborts immediately. ARVALID drops even without a handshake; this is acceptable because the interconnect resets with `rst`.
- Latency:
  - `I_req` sampled in IDLE at cycle N gives ARVALID=1 at cycle N+1.
  - ARREADY at cycle M gives RREADY=1 from cycle M+1.
- Data path is zero-latency: RDATA reaches `I_out` in the same cycle the beat is accepted. The cache writes the data array on that edge.
- A new request can be accepted no earlier than one cycle after `I_req` falls in HOLD.
- If ARREADY and the first RVALID arrive in the same cycle, that beat is not accepted (RREADY=0 in ADDR). It is taken on a later cycle.
- `I_req` falling in ADDR or DATA is ignored; the burst always completes.

## Structure
- Shared package `axi_pkg`:
  - Constants: `AXI_SIZE_4B`=3'b010, `AXI_BURST_INCR`=2'b01, `AXI_RESP_OKAY`=2'b00.
  - State enum typedef `ird_state_e`.
- No sub-modules; a single FSM with its counter.

## Test plan
- Single refill: I_addr=32'h0000_1234, ARREADY after 2 cycles, 4 beats back to back with RLAST on beat 3 -> ARADDR=32'h0000_1230, ARLEN=3, `RVALID_c` for 4 cycles, `RLAST_c` only on beat 3, err=0.
- Wait states: RVALID toggles 1,0,0,1,1,0,1 -> `I_out` matches exactly the accepted beats, 4 in total, in order.
- Error response: RRESP=2'b10 on beat 1 -> `err`=1 from the next cycle onward, the burst still completes, `err` stays 1 through following clean bursts.
- Protocol check: RLAST on beat 1 -> `proto_err`=1, the FSM still waits for beats 2 and 3. RLAST=0 on beat 3 in a separate run -> `proto_err`=1.
- HOLD: `I_req` held for 3 cycles after the last beat -> no second ARVALID; a new `I_req` one cycle after the drop -> ARVALID the cycle after that.
- Reset mid-DATA after 2 beats -> next cycle ARVALID=0, RREADY=0, `busy`=0; a new request starts with `beat_cnt`=0.
